// File: rtl/girl10_pkg.sv
// rtl/girl10_pkg.sv - shared defaults, counter width and top FSM states for the input conditioner
package girl10_pkg;

    localparam int NX_DEF  = 7;
    localparam int DEB_DEF = 4;
    localparam int CNT_W   = 4;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/girl10_deb_bit.sv
// rtl/girl10_deb_bit.sv - one input bit: two-flop synchronizer, debounce counter and change pulse
module girl10_deb_bit
    import girl10_pkg::*;
#(
    parameter int   DEB     = DEB_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_run,
    output logic o_clean,
    output logic o_chg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_clean;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_clean <= RST_VAL;
            r_chg   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_chg <= 1'b0;
            // While settling the output simply tracks the synchronizer.
            if (!i_run) begin
                r_clean <= r_s2;
                r_cnt   <= '0;
            end else if (r_s2 == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_clean <= r_s2;
                r_cnt   <= '0;
                r_chg   <= 1'b1;
            end
        end
    end

    assign o_clean = r_clean;
    assign o_chg   = r_chg;

endmodule

// File: rtl/girl10_in_cond.sv
// rtl/girl10_in_cond.sv - conditions raw controller inputs and latches the key bit
module girl10_in_cond
    import girl10_pkg::*;
#(
    parameter int            NX      = NX_DEF,
    parameter int            DEB     = DEB_DEF,
    parameter logic [NX-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NX-1:0] x_raw,
    input  logic          key_raw,
    input  logic          key_load,
    output logic [NX-1:0] x_clean,
    output logic          keyinput0,
    output logic [NX-1:0] chg,
    output logic          valid,
    output logic          key_locked
);

    // One bit wider than the debounce counter so DEB+1 fits for DEB up to 15.
    localparam logic [CNT_W:0] SETTLE_END = (CNT_W + 1)'(DEB + 1);

    state_t         r_state;
    logic [CNT_W:0] r_settle_cnt;
    logic           r_valid;
    logic           r_key_s1;
    logic           r_key_s2;
    logic           r_keyinput0;
    logic           r_key_locked;
    logic           w_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_END) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_s1     <= 1'b0;
            r_key_s2     <= 1'b0;
            r_keyinput0  <= 1'b0;
            r_key_locked <= 1'b0;
        end else begin
            r_key_s1 <= key_raw;
            r_key_s2 <= r_key_s1;
            if (key_load && !r_key_locked) begin
                r_keyinput0  <= r_key_s2;
                r_key_locked <= 1'b1;
            end
        end
    end

    assign w_run = (r_state == RUN);

    for (genvar gi = 0; gi < NX; gi++) begin : g_bit
        girl10_deb_bit #(
            .DEB     (DEB),
            .RST_VAL (RST_VAL[gi])
        ) u_bit (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_raw   (x_raw[gi]),
            .i_run   (w_run),
            .o_clean (x_clean[gi]),
            .o_chg   (chg[gi])
        );
    end

    assign valid      = r_valid;
    assign keyinput0  = r_keyinput0;
    assign key_locked = r_key_locked;

endmodule

// File: doc/girl10_in_cond.md
GIRL10_IN_COND -- requirements
Module: girl10_in_cond

Interface
REQ-001 SHALL provide parameter NX, default 7, the number of conditioned controller inputs (x1..x7).
REQ-002 SHALL provide parameter DEB, default 4, the debounce length in clk cycles; legal range 2..15.
REQ-003 SHALL provide parameter RST_VAL, default all-zero NX bits, the reset value of x_clean.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 x_raw  in  NX  asynchronous raw inputs; bit i feeds controller input x(i+1).
REQ-007 key_raw  in  1  asynchronous raw key-bit source.
REQ-008 key_load  in  1  synchronous one-cycle request to latch the key bit.
REQ-009 x_clean  out  NX  debounced inputs to the downstream FSM controller.
REQ-010 keyinput0  out  1  latched key bit to the downstream controller.
REQ-011 chg  out  NX  one-cycle pulse per bit when x_clean(i) changes.
REQ-012 valid  out  1  high once x_clean is settled after reset.
REQ-013 key_locked  out  1  high once keyinput0 is latched.

Function
REQ-014 Each x_raw bit and key_raw SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 Top FSM states SHALL be SETTLE and RUN only; reset enters SETTLE.
REQ-016 In SETTLE: x_clean loads s2 every cycle, no debounce, chg held 0, valid 0, settle counter increments.
REQ-017 SETTLE -> RUN SHALL occur when the settle counter reaches DEB+1, i.e. valid rises on the (DEB+2)th rising edge after reset release.
REQ-018 RUN SHALL have no exit other than reset.
REQ-019 In RUN, per bit: if s2 equals x_clean, cnt clears to 0.
REQ-020 Otherwise, if cnt is below DEB-1, cnt increments.
REQ-021 Otherwise (cnt at DEB-1), x_clean(i) takes s2, cnt clears to 0, and chg(i) pulses for exactly one cycle.
REQ-022 A raw change held stable from before edge 0 SHALL reach x_clean at edge DEB+1, a latency of DEB+2 edges.
REQ-023 A glitch shorter than DEB cycles at s2 SHALL NOT change x_clean; cnt restarts from 0 on every mismatch-free cycle.
REQ-024 Bits SHALL debounce independently; simultaneous changes on several bits SHALL produce simultaneous chg pulses.
REQ-025 key_load high with key_locked low SHALL copy synchronized key_raw into keyinput0 and set key_locked on the same edge.
REQ-026 key_load with key_locked high SHALL be ignored.
REQ-027 key_load is honoured in SETTLE and in RUN.
REQ-028 All outputs SHALL be registered; x_clean changes on rising edges only, giving the falling-edge-sampling controller a half-cycle setup margin.

Reset
REQ-029 Asserting rst SHALL immediately force: state SETTLE, settle counter 0, all cnt 0, synchronizers 0, x_clean=RST_VAL, chg=0, valid=0, keyinput0=0, key_locked=0.
REQ-030 Reset mid-debounce SHALL discard partial counts; no chg pulse results.

Structure
REQ-031 Shared package girl10_pkg SHALL hold the NX and DEB defaults, the counter width constant (4 bits), and the SETTLE/RUN state enum.
REQ-032 Per-bit synchronizer, debounce counter and chg logic SHALL be a sub-module girl10_deb_bit, instantiated NX times through a generate loop.
REQ-033 The key synchronizer, key latch and top FSM SHALL reside in girl10_in_cond.

Verification
REQ-034 Release rst with x_raw=7'h25 -> valid=0 for edges 1..5; valid=1 and x_clean=7'h25 at edge 6 (DEB=4); chg stays 0.
REQ-035 In RUN, x_raw bit5 0->1 held -> x_clean[5]=1 exactly 6 edges later; chg[5] high for that single cycle only.
REQ-036 In RUN, 3-cycle pulse on x_raw bit0 -> x_clean[0] unchanged, chg[0] never asserted.
REQ-037 key_raw=1, key_load pulse -> keyinput0=1, key_locked=1; key_raw=0 with a second key_load -> keyinput0 stays 1.
REQ-038 Assert rst while bit3 cnt=2 -> all outputs take reset values at once; after release, SETTLE runs again with no chg pulse.
REQ-039 Flip bits 1 and 6 on the same cycle -> both x_clean bits and both chg bits update on the same edge.
